// File: rtl/ex_stage_pkg.sv
// Shared types and field layout for the execute stage: ID->EX bus layout,
// ALU one-hot indices, control bits and divider FSM states.
package ex_stage_pkg;

    localparam int ID2EX_W  = 153;
    localparam int EX2MEM_W = 72;
    localparam int EXFWD_W  = 39;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef struct packed {
        logic div_en;
        logic div_signed;
        logic div_mod;
        logic mem_we;
        logic mem_re;
        logic res_from_mem;
    } ctrl_t;

    typedef struct packed {
        logic        rsvd;
        logic [11:0] alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        ctrl_t       ctrl;
        logic [31:0] st_data;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] pc;
    } id2ex_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider on operand magnitudes: one quotient bit per cycle,
// result held in DONE until the owning instruction leaves EX.
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] LAST = 5'(DIV_CYCLES - 1);

    div_state_e  state_r, state_nx;
    logic [4:0]  count_r;
    logic [31:0] rem_r, quo_r, dsor_r;
    logic        neg_q_r, neg_r_r, zero_r;

    logic [31:0] dvd_mag, dsor_mag;
    logic [32:0] shifted, diff;
    logic        q_bit;

    assign dvd_mag  = (is_signed & dividend[31]) ? -dividend : dividend;
    assign dsor_mag = (is_signed & divisor[31])  ? -divisor  : divisor;

    // Quotient register doubles as the dividend shift register.
    assign shifted = {rem_r, quo_r[31]};
    assign diff    = shifted - {1'b0, dsor_r};
    assign q_bit   = ~diff[32];

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            DIV_IDLE: if (start)            state_nx = DIV_BUSY;
            DIV_BUSY: if (count_r == LAST)  state_nx = DIV_DONE;
            DIV_DONE: if (ack)              state_nx = DIV_IDLE;
            default:                        state_nx = DIV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= DIV_IDLE;
            count_r <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            dsor_r  <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            case (state_r)
                DIV_IDLE: if (start) begin
                    quo_r   <= dvd_mag;
                    rem_r   <= '0;
                    dsor_r  <= dsor_mag;
                    neg_q_r <= is_signed & (dividend[31] ^ divisor[31]);
                    neg_r_r <= is_signed & dividend[31];
                    zero_r  <= (divisor == 32'h0);
                    count_r <= '0;
                end
                DIV_BUSY: begin
                    rem_r   <= q_bit ? diff[31:0] : shifted[31:0];
                    quo_r   <= {quo_r[30:0], q_bit};
                    count_r <= count_r + 5'd1;  // wraps back to 0 on the last step
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_r == DIV_BUSY);
    assign done      = (state_r == DIV_DONE);
    assign quotient  = zero_r ? 32'hffff_ffff : (neg_q_r ? -quo_r : quo_r);
    assign remainder = neg_r_r ? -rem_r : rem_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registers the ID->EX bus, evaluates the one-hot ALU op inline or
// runs the iterative divider, issues the data-SRAM request and drives EX->MEM.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ctl_id_over_i,
    output logic                ctl_ex_allow_in_o,
    input  logic [ID2EX_W-1:0]  id2ex_bus_i,
    output logic                ctl_ex_over_o,
    input  logic                ctl_mem_allow_in_i,
    output logic [EX2MEM_W-1:0] ex2mem_bus_o,
    output logic [EXFWD_W-1:0]  ex_fwd_o,
    output logic                data_sram_en_o,
    output logic [3:0]          data_sram_we_o,
    output logic [31:0]         data_sram_addr_o,
    output logic [31:0]         data_sram_wdata_o
);

    logic   ex_valid_r;
    id2ex_t bus_r;
    ctrl_t  ctrl;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_r <= 1'b0;
            bus_r      <= '0;
        end else if (ctl_ex_allow_in_o) begin
            ex_valid_r <= ctl_id_over_i;
            if (ctl_id_over_i) bus_r <= id2ex_bus_i;
        end
    end

    assign ctrl = bus_r.ctrl;

    logic rsvd_unused;
    assign rsvd_unused = bus_r.rsvd;

    // ALU: one-hot select, so each result is masked and OR-ed together.
    logic [11:0] op;
    logic [31:0] src1, src2, add_res, sub_res, alu_res;
    logic [4:0]  shamt;

    assign op      = bus_r.alu_op;
    assign src1    = bus_r.src1;
    assign src2    = bus_r.src2;
    assign shamt   = src2[4:0];
    assign add_res = src1 + src2;
    assign sub_res = src1 - src2;

    always_comb begin
        alu_res = ({32{op[ALU_ADD]}}  & add_res)
                | ({32{op[ALU_SUB]}}  & sub_res)
                | ({32{op[ALU_SLT]}}  & {31'b0, $signed(src1) < $signed(src2)})
                | ({32{op[ALU_SLTU]}} & {31'b0, src1 < src2})
                | ({32{op[ALU_AND]}}  & (src1 & src2))
                | ({32{op[ALU_NOR]}}  & ~(src1 | src2))
                | ({32{op[ALU_OR]}}   & (src1 | src2))
                | ({32{op[ALU_XOR]}}  & (src1 ^ src2))
                | ({32{op[ALU_SLL]}}  & (src1 << shamt))
                | ({32{op[ALU_SRL]}}  & (src1 >> shamt))
                | ({32{op[ALU_SRA]}}  & 32'($signed(src1) >>> shamt))
                | ({32{op[ALU_LUI]}}  & src2);
    end

    logic        div_busy_unused, div_done;
    logic [31:0] div_quo, div_rem, result;

    ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (ex_valid_r & ctrl.div_en),
        .is_signed (ctrl.div_signed),
        .dividend  (src1),
        .divisor   (src2),
        .ack       (ctl_mem_allow_in_i),
        .busy      (div_busy_unused),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign result = ctrl.div_en ? (ctrl.div_mod ? div_rem : div_quo) : alu_res;

    assign ctl_ex_over_o     = ex_valid_r & (~ctrl.div_en | div_done);
    assign ctl_ex_allow_in_o = ~ex_valid_r | (ctl_ex_over_o & ctl_mem_allow_in_i);

    assign ex2mem_bus_o = {ctrl.res_from_mem, ctrl.mem_we, bus_r.dest, bus_r.gr_we, result, bus_r.pc};
    assign ex_fwd_o     = {ex_valid_r & bus_r.gr_we, bus_r.dest, result, ctrl.res_from_mem};

    // The request fires on the same cycle the instruction hands over to MEM, so it pulses once.
    assign data_sram_en_o    = ex_valid_r & (ctrl.mem_re | ctrl.mem_we) & ctl_mem_allow_in_i;
    assign data_sram_we_o    = (ex_valid_r & ctrl.mem_we) ? 4'hf : 4'h0;
    assign data_sram_addr_o  = add_res;
    assign data_sram_wdata_o = bus_r.st_data;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: stimulus pushes expected EX->MEM words into a queue,
// a negedge monitor pops and compares on every EX->MEM handover.
module tb_ex_stage;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         ctl_id_over_i = 1'b0;
    logic         ctl_mem_allow_in_i = 1'b1;
    logic [152:0] id2ex_bus_i = '0;
    logic         ctl_ex_allow_in_o, ctl_ex_over_o;
    logic [71:0]  ex2mem_bus_o;
    logic [38:0]  ex_fwd_o;
    logic         data_sram_en_o;
    logic [3:0]   data_sram_we_o;
    logic [31:0]  data_sram_addr_o, data_sram_wdata_o;

    ex_stage dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ctl_id_over_i      (ctl_id_over_i),
        .ctl_ex_allow_in_o  (ctl_ex_allow_in_o),
        .id2ex_bus_i        (id2ex_bus_i),
        .ctl_ex_over_o      (ctl_ex_over_o),
        .ctl_mem_allow_in_i (ctl_mem_allow_in_i),
        .ex2mem_bus_o       (ex2mem_bus_o),
        .ex_fwd_o           (ex_fwd_o),
        .data_sram_en_o     (data_sram_en_o),
        .data_sram_we_o     (data_sram_we_o),
        .data_sram_addr_o   (data_sram_addr_o),
        .data_sram_wdata_o  (data_sram_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;
    localparam logic [11:0] OP_NONE = 12'h000;

    // {div_en, div_signed, div_mod, mem_we, mem_re, res_from_mem}
    localparam logic [5:0] C_ALU  = 6'b000000;
    localparam logic [5:0] C_DIVU = 6'b100000;
    localparam logic [5:0] C_MODU = 6'b101000;
    localparam logic [5:0] C_DIV  = 6'b110000;
    localparam logic [5:0] C_MOD  = 6'b111000;
    localparam logic [5:0] C_ST   = 6'b000100;

    int checks = 0;
    int errors = 0;
    logic [71:0] sb_q[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i && ctl_ex_over_o && ctl_mem_allow_in_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h with empty scoreboard", ex2mem_bus_o);
            end else begin
                check("sb_bus", ex2mem_bus_o, sb_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the instruction entered EX.
    task automatic issue(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [5:0] ctrl, input logic [31:0] st, input logic [4:0] dest,
                         input logic gr_we, input logic [31:0] pc, input logic [31:0] exp_res);
        int n = 0;
        while (!ctl_ex_allow_in_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!ctl_ex_allow_in_o) begin
            checks++;
            errors++;
            $display("FAIL allow_in_timeout: got 0 expected 1");
        end
        id2ex_bus_i   = {1'b0, op, s1, s2, ctrl, st, dest, gr_we, pc};
        ctl_id_over_i = 1'b1;
        sb_q.push_back({ctrl[0], ctrl[2], dest, gr_we, exp_res, pc});
        @(posedge clk_i); #1;
        ctl_id_over_i = 1'b0;
    endtask

    task automatic wait_over(input string name, input int exp_lat);
        int n = 0;
        while (!ctl_ex_over_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check(name, 72'(n), 72'(exp_lat));
    endtask

    // Issue, check latency, let it hand over to MEM.
    task automatic run(input string name, input logic [11:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [5:0] ctrl, input logic [31:0] exp_res,
                       input int exp_lat);
        issue(op, s1, s2, ctrl, 32'h0, 5'd3, 1'b1, 32'h0000_0100, exp_res);
        wait_over(name, exp_lat);
        @(posedge clk_i); #1;
    endtask

    initial begin
        // Reset values
        #3;
        check("rst_over", 72'(ctl_ex_over_o), 72'h0);
        check("rst_allow_in", 72'(ctl_ex_allow_in_o), 72'h1);
        check("rst_sram_en", 72'(data_sram_en_o), 72'h0);
        check("rst_sram_we", 72'(data_sram_we_o), 72'h0);
        check("rst_fwd_valid", 72'(ex_fwd_o[38]), 72'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Single-cycle add with forwarding info
        issue(OP_ADD, 32'd5, 32'd7, C_ALU, 32'h0, 5'd9, 1'b1, 32'h0000_0040, 32'd12);
        check("add_over", 72'(ctl_ex_over_o), 72'h1);
        check("add_sram_en", 72'(data_sram_en_o), 72'h0);
        check("add_fwd", 72'(ex_fwd_o), 72'({1'b1, 5'd9, 32'd12, 1'b0}));
        @(posedge clk_i); #1;

        // ALU patterns
        run("sra_lat",  OP_SRA,  32'h8000_0000, 32'd4,         C_ALU, 32'hf800_0000, 0);
        run("sltu_lat", OP_SLTU, 32'h0000_0001, 32'hffff_ffff, C_ALU, 32'h0000_0001, 0);
        run("sub_lat",  OP_SUB,  32'd3,         32'd5,         C_ALU, 32'hffff_fffe, 0);
        run("lui_lat",  OP_LUI,  32'hdead_beef, 32'h1234_5000, C_ALU, 32'h1234_5000, 0);
        run("sll_lat",  OP_SLL,  32'h0000_0001, 32'h0000_003f, C_ALU, 32'h8000_0000, 0);
        run("nor_lat",  OP_NOR,  32'h0f0f_0000, 32'h0000_00ff, C_ALU, 32'hf0f0_ff00, 0);

        // Divides: 33 cycles from entry
        run("div_s_lat",   OP_NONE, 32'hffff_fff9, 32'd2,         C_DIV,  32'hffff_fffd, 33);
        run("mod_s_lat",   OP_NONE, 32'hffff_fff9, 32'd2,         C_MOD,  32'hffff_ffff, 33);
        run("divu_z_lat",  OP_NONE, 32'd100,       32'd0,         C_DIVU, 32'hffff_ffff, 33);
        run("modu_z_lat",  OP_NONE, 32'd100,       32'd0,         C_MODU, 32'd100,       33);
        run("div_ovf_lat", OP_NONE, 32'h8000_0000, 32'hffff_ffff, C_DIV,  32'h8000_0000, 33);
        run("mod_ovf_lat", OP_NONE, 32'h8000_0000, 32'hffff_ffff, C_MOD,  32'h0000_0000, 33);

        // Back-to-back divides: second enters as the first leaves
        issue(OP_NONE, 32'd100, 32'd7, C_DIVU, 32'h0, 5'd3, 1'b1, 32'h0000_0100, 32'd14);
        issue(OP_NONE, 32'd100, 32'd7, C_MODU, 32'h0, 5'd3, 1'b1, 32'h0000_0100, 32'd2);
        wait_over("b2b_lat", 33);
        @(posedge clk_i); #1;

        // Store held by a MEM stall
        ctl_mem_allow_in_i = 1'b0;
        issue(OP_ADD, 32'h0000_0ff0, 32'h0000_0010, C_ST, 32'hdead_beef, 5'd0, 1'b0,
              32'h0000_0200, 32'h0000_1000);
        for (int i = 0; i < 3; i++) begin
            check("st_stall_en", 72'(data_sram_en_o), 72'h0);
            check("st_stall_bus", ex2mem_bus_o, {1'b0, 1'b1, 5'd0, 1'b0, 32'h0000_1000, 32'h0000_0200});
            @(posedge clk_i); #1;
        end
        ctl_mem_allow_in_i = 1'b1;
        #1;
        check("st_en", 72'(data_sram_en_o), 72'h1);
        check("st_we", 72'(data_sram_we_o), 72'hf);
        check("st_addr", 72'(data_sram_addr_o), 72'h1000);
        check("st_wdata", 72'(data_sram_wdata_o), 72'hdead_beef);
        @(posedge clk_i); #1;
        check("st_en_after", 72'(data_sram_en_o), 72'h0);

        // Reset mid-divide
        issue(OP_NONE, 32'hffff_fff9, 32'd2, C_DIV, 32'h0, 5'd3, 1'b1, 32'h0000_0100, 32'hffff_fffd);
        repeat (10) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_over", 72'(ctl_ex_over_o), 72'h0);
        check("mid_rst_allow_in", 72'(ctl_ex_allow_in_o), 72'h1);
        check("mid_rst_sram_en", 72'(data_sram_en_o), 72'h0);
        check("mid_rst_fwd_valid", 72'(ex_fwd_o[38]), 72'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (40) @(posedge clk_i);
        #1;
        check("no_stale_done", 72'(ctl_ex_over_o), 72'h0);
        issue(OP_ADD, 32'h11, 32'h22, C_ALU, 32'h0, 5'd4, 1'b1, 32'h0000_0300, 32'h33);
        check("post_rst_over", 72'(ctl_ex_over_o), 72'h1);
        @(posedge clk_i); #1;

        check("sb_drained", 72'(sb_q.size()), 72'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
